front_sprite_animator: RTL and testbench
========================================

Name: front_sprite_animator

Overview:
- Control stage directly upstream of the front-sprite ROM renderer in the battle scene.
- Turns species selection and battle events (enter, hit, faint) into per-frame sprite position (x, y), sprite-sheet offsets (sel_x, sel_y) and a visibility flag.
- Outputs feed the renderer's x_in/y_in/sprite_sel_x/sprite_sel_y; visible_out gates the renderer's pixel_out in the compositor mux.
- All motion advances once per video frame, so outputs stay constant for the whole visible frame.

Parameters:
- START_X, 1024: off-screen x where the slide-in begins.
- REST_X, 600: resting x of the sprite's top-left corner.
- REST_Y, 100: resting y.
- STEP_PX, 8: pixels moved per frame in the slide and faint states.
- BLINK_FRAMES, 4: frames per visibility toggle while in HIT.
- HIT_TOGGLES, 6: number of toggles in one hit animation (even, so the sprite ends visible).
- SHAKE_PX, 4: horizontal shake amplitude; used only with SPRITE_SHAKE_EN.

Ports:
- pixel_clk_in  in  1  pixel clock, the only clock.
- rst_n_in  in  1  synchronous, active-low reset.
- vsync_in  in  1  VGA vsync (active-low pulse). Its falling edge is the frame tick.
- start_in  in  1  one-cycle pulse: load species and begin slide-in.
- species_in  in  5  species index 0..27, sampled with start_in.
- hit_in  in  1  one-cycle pulse: play the hit blink.
- faint_in  in  1  one-cycle pulse: play the faint sink.
- x_out  out  11  sprite x position.
- y_out  out  10  sprite y position.
- sprite_sel_x_out  out  10  sheet x offset.
- sprite_sel_y_out  out  9  sheet y offset.
- visible_out  out  1  renderer output enable.
- busy_out  out  1  high in SLIDE_IN, HIT or FAINT.
- done_out  out  1  one-cycle pulse when any animation completes.

Behaviour:
Clock and reset
- One clock; reset is synchronous and active-low (pixel_clk_in, rst_n_in).
- Reset values: x_out=START_X, y_out=REST_Y, sel_x=0, sel_y=0, visible_out=0, busy_out=0, done_out=0, state=IDLE, pending commands cleared.
- Reset mid-animation aborts it immediately. No done_out pulse is produced.

Frame tick
- tick = 1 in the cycle after vsync_in is sampled 1 then 0 (two-flop edge detector).
- The first tick after reset requires a prior high sample of vsync_in.

Command capture
- Commands are latched on any cycle into a pending register and consumed at the next tick.
- If several commands are pending at a tick, priority is start > faint > hit. Lower-priority pending commands are discarded.
- Commands are accepted only in these states:
  - start: any state.
  - hit: REST only.
  - faint: REST or HIT.
- A command that arrives in any other state is dropped at the tick.
- start with species_in > 27 is dropped at capture.

Sheet address (computed at start capture)
- col = species % 14, row = species / 14.
- sel_x = col*56 (max 728, fits in 10 bits); sel_y = row*56.
- Both are held until the next accepted start.

State machine (evaluated on tick only; registered outputs update in the same edge)
- IDLE: visible=0.
  - start → SLIDE_IN: x=START_X, y=REST_Y, visible=1.
- SLIDE_IN: each tick, x = (x − STEP_PX < REST_X) ? REST_X : x − STEP_PX.
  - Compute in 12 bits so no underflow occurs.
  - When x reaches REST_X → REST, with done pulse.
- REST: visible=1; x, y fixed.
  - hit → HIT.
  - faint → FAINT.
- HIT: frame counter counts to BLINK_FRAMES−1; on wrap visible toggles and the toggle counter increments.
  - After HIT_TOGGLES toggles → REST, visible=1, done pulse.
  - faint during HIT → FAINT with visible forced to 1.
- FAINT: each tick y += STEP_PX.
  - When y ≥ REST_Y+56 → IDLE, visible=0, y=REST_Y, done pulse.

Status outputs
- done_out is a one-cycle pulse on the tick edge of the completing transition.
- busy_out is registered alongside the state.
- A start in any state restarts the slide-in from START_X. A preempted animation does not produce a done pulse.

Optional Feature:
SPRITE_SHAKE_EN
- Defined: in HIT, x_out = REST_X + SHAKE_PX on even frame-counter values and REST_X − SHAKE_PX on odd values. x returns to REST_X on exiting HIT.
- Undefined: x_out stays at REST_X during HIT; the state machine is blink-only. SHAKE_PX is unused.

Decomposition:
Shared package battle_sprite_pkg:
- SPRITE_DIM=56, SHEET_COLS=14, SHEET_ROWS=2, NUM_SPECIES=28.
- typedef enum anim_state_t {IDLE, SLIDE_IN, REST, HIT, FAINT}.
- typedef species_t (5-bit logic).

Sub-module:
- frame_tick_gen: vsync falling-edge detector. It is reused by other per-frame animators.

Test Plan:
- Reset, then start_in with species=17 → at the first tick sel_x=168, sel_y=56, x=1024, visible=1. After 53 ticks x=600, state=REST, one done pulse. busy_out low afterwards.
- start_in with species=30 → ignored. Outputs unchanged, busy_out stays 0.
- In REST, hit_in → visible toggles every 4 ticks, 6 toggles total. Ends visible=1 at tick 24, done pulse.
- In REST, faint_in → y = 108, 116, …, reaches 156 on the 7th tick, then visible=0, IDLE, done pulse.
- hit_in and faint_in in the same frame in REST → FAINT taken, hit discarded. start_in during FAINT → x reloads to 1024 with no done pulse.
- rst_n_in low for 1 cycle mid-SLIDE_IN → next cycle all outputs equal reset values. SPRITE_SHAKE_EN build: x alternates 604/596 during HIT.

Source files
------------

// File: rtl/battle_sprite_pkg.sv
// Shared types and sprite-sheet geometry for the battle-scene sprite animators.
package battle_sprite_pkg;

  localparam int unsigned SPRITE_DIM  = 56;
  localparam int unsigned SHEET_COLS  = 14;
  localparam int unsigned SHEET_ROWS  = 2;
  localparam int unsigned NUM_SPECIES = SHEET_COLS * SHEET_ROWS;

  typedef enum logic [2:0] {
    IDLE,
    SLIDE_IN,
    REST,
    HIT,
    FAINT
  } anim_state_t;

  typedef logic [4:0] species_t;

  function automatic logic [9:0] sheet_sel_x(input species_t sp);
    int unsigned col;
    col = 32'(sp) % SHEET_COLS;
    return 10'(col * SPRITE_DIM);
  endfunction

  function automatic logic [8:0] sheet_sel_y(input species_t sp);
    int unsigned row;
    row = 32'(sp) / SHEET_COLS;
    return 9'(row * SPRITE_DIM);
  endfunction

  function automatic logic species_valid(input species_t sp);
    return 32'(sp) < NUM_SPECIES;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vsync falling-edge detector: one-cycle frame tick, shared by per-frame animators.
module frame_tick_gen (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic vsync_in,
  output logic tick_out
);

  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    sync_d = vsync_in;
    prev_d = sync_q;
  end

  // Both flops clear on reset, so the first tick needs a real high-then-low sample.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign tick_out = prev_q & ~sync_q;

endmodule

// File: rtl/front_sprite_animator.sv
// Front-sprite motion/visibility controller; all motion advances on the frame tick.
// Optional horizontal shake during HIT is enabled by defining SPRITE_SHAKE_EN.
module front_sprite_animator
  import battle_sprite_pkg::*;
#(
  parameter int unsigned START_X      = 1024,
  parameter int unsigned REST_X       = 600,
  parameter int unsigned REST_Y       = 100,
  parameter int unsigned STEP_PX      = 8,
  parameter int unsigned BLINK_FRAMES = 4,
  parameter int unsigned HIT_TOGGLES  = 6
`ifdef SPRITE_SHAKE_EN
  ,
  parameter int unsigned SHAKE_PX     = 4
`endif
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        vsync_in,
  input  logic        start_in,
  input  logic [4:0]  species_in,
  input  logic        hit_in,
  input  logic        faint_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [9:0]  sprite_sel_x_out,
  output logic [8:0]  sprite_sel_y_out,
  output logic        visible_out,
  output logic        busy_out,
  output logic        done_out
);

  logic tick;

  frame_tick_gen u_tick (
    .clk_in   (pixel_clk_in),
    .rst_n_in (rst_n_in),
    .vsync_in (vsync_in),
    .tick_out (tick)
  );

  anim_state_t state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [9:0]  sel_x_q, sel_x_d;
  logic [8:0]  sel_y_q, sel_y_d;
  logic        vis_q, vis_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  toggle_cnt_q, toggle_cnt_d;

  logic        pend_start_q, pend_start_d;
  logic        pend_hit_q, pend_hit_d;
  logic        pend_faint_q, pend_faint_d;
  logic [9:0]  pend_sel_x_q, pend_sel_x_d;
  logic [8:0]  pend_sel_y_q, pend_sel_y_d;

  // A tick consumes the pending set; a command arriving on the tick cycle waits for the next one.
  always_comb begin
    pend_start_d = pend_start_q;
    pend_hit_d   = pend_hit_q;
    pend_faint_d = pend_faint_q;
    pend_sel_x_d = pend_sel_x_q;
    pend_sel_y_d = pend_sel_y_q;
    if (tick) begin
      pend_start_d = 1'b0;
      pend_hit_d   = 1'b0;
      pend_faint_d = 1'b0;
    end
    if (start_in && species_valid(species_in)) begin
      pend_start_d = 1'b1;
      pend_sel_x_d = sheet_sel_x(species_in);
      pend_sel_y_d = sheet_sel_y(species_in);
    end
    if (hit_in) begin
      pend_hit_d = 1'b1;
    end
    if (faint_in) begin
      pend_faint_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sel_x_d      = sel_x_q;
    sel_y_d      = sel_y_q;
    vis_d        = vis_q;
    done_d       = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;

    if (tick) begin
      if (pend_start_q) begin
        state_d      = SLIDE_IN;
        x_d          = 11'(START_X);
        y_d          = 10'(REST_Y);
        vis_d        = 1'b1;
        sel_x_d      = pend_sel_x_q;
        sel_y_d      = pend_sel_y_q;
        frame_cnt_d  = '0;
        toggle_cnt_d = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            vis_d = 1'b0;
          end
          SLIDE_IN: begin
            // Compare against REST_X + STEP_PX so the subtraction can never wrap.
            if ({1'b0, x_q} < 12'(REST_X + STEP_PX)) begin
              x_d = 11'(REST_X);
            end else begin
              x_d = x_q - 11'(STEP_PX);
            end
            if (x_d == 11'(REST_X)) begin
              state_d = REST;
              done_d  = 1'b1;
            end
          end
          REST: begin
            vis_d = 1'b1;
            if (pend_faint_q) begin
              state_d = FAINT;
            end else if (pend_hit_q) begin
              state_d      = HIT;
              frame_cnt_d  = '0;
              toggle_cnt_d = '0;
            end
          end
          HIT: begin
            if (pend_faint_q) begin
              state_d = FAINT;
              vis_d   = 1'b1;
              x_d     = 11'(REST_X);
            end else if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
              frame_cnt_d = '0;
              vis_d       = ~vis_q;
              if (toggle_cnt_q == 8'(HIT_TOGGLES - 1)) begin
                state_d      = REST;
                vis_d        = 1'b1;
                x_d          = 11'(REST_X);
                toggle_cnt_d = '0;
                done_d       = 1'b1;
              end else begin
                toggle_cnt_d = toggle_cnt_q + 8'd1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
          FAINT: begin
            if (y_q >= 10'(REST_Y + SPRITE_DIM)) begin
              state_d = IDLE;
              vis_d   = 1'b0;
              y_d     = 10'(REST_Y);
              done_d  = 1'b1;
            end else begin
              y_d = y_q + 10'(STEP_PX);
            end
          end
          default: begin
            state_d = IDLE;
            vis_d   = 1'b0;
          end
        endcase
      end
`ifdef SPRITE_SHAKE_EN
      if (state_d == HIT) begin
        x_d = frame_cnt_d[0] ? 11'(REST_X - SHAKE_PX) : 11'(REST_X + SHAKE_PX);
      end
`endif
    end

    busy_d = (state_d == SLIDE_IN) || (state_d == HIT) || (state_d == FAINT);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      x_q          <= 11'(START_X);
      y_q          <= 10'(REST_Y);
      sel_x_q      <= '0;
      sel_y_q      <= '0;
      vis_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      pend_start_q <= 1'b0;
      pend_hit_q   <= 1'b0;
      pend_faint_q <= 1'b0;
      pend_sel_x_q <= '0;
      pend_sel_y_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sel_x_q      <= sel_x_d;
      sel_y_q      <= sel_y_d;
      vis_q        <= vis_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      pend_start_q <= pend_start_d;
      pend_hit_q   <= pend_hit_d;
      pend_faint_q <= pend_faint_d;
      pend_sel_x_q <= pend_sel_x_d;
      pend_sel_y_q <= pend_sel_y_d;
    end
  end

  assign x_out            = x_q;
  assign y_out            = y_q;
  assign sprite_sel_x_out = sel_x_q;
  assign sprite_sel_y_out = sel_y_q;
  assign visible_out      = vis_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;

endmodule

// File: tb/tb_front_sprite_animator.sv
// Scoreboard bench: frame-level reference model feeds a queue, a monitor checks each frame.
module tb_front_sprite_animator;

  localparam int START_X = 1024;
  localparam int REST_X  = 600;
  localparam int REST_Y  = 100;
  localparam int STEP    = 8;
  localparam int SHAKE   = 4;

  localparam int M_IDLE  = 0;
  localparam int M_SLIDE = 1;
  localparam int M_REST  = 2;
  localparam int M_HIT   = 3;
  localparam int M_FAINT = 4;

  logic        clk = 1'b0;
  logic        rst_n, vsync, start, hit, faint;
  logic [4:0]  species;
  logic [10:0] x;
  logic [9:0]  y;
  logic [9:0]  selx;
  logic [8:0]  sely;
  logic        vis, busy, done;

  always #5 clk = ~clk;

  front_sprite_animator dut (
    .pixel_clk_in     (clk),
    .rst_n_in         (rst_n),
    .vsync_in         (vsync),
    .start_in         (start),
    .species_in       (species),
    .hit_in           (hit),
    .faint_in         (faint),
    .x_out            (x),
    .y_out            (y),
    .sprite_sel_x_out (selx),
    .sprite_sel_y_out (sely),
    .visible_out      (vis),
    .busy_out         (busy),
    .done_out         (done)
  );

  typedef struct {
    string tag;
    int    x, y, selx, sely, vis, busy, done;
  } exp_t;

  exp_t sbq[$];
  int   issued    = 0;
  bit   stim_done = 1'b0;
  int   done_cnt  = 0;
  int   total     = 0;
  int   bad       = 0;

  // Reference model state: phase, elapsed ticks in the phase, and visible outputs.
  int m_st, m_n, m_x, m_y, m_selx, m_sely, m_vis;

  always @(negedge clk) if (done) done_cnt++;

  task automatic model_reset();
    m_st = M_IDLE; m_n = 0; m_x = START_X; m_y = REST_Y;
    m_selx = 0; m_sely = 0; m_vis = 0;
  endtask

  task automatic model_tick(input bit s, input int sp, input bit h, input bit f, output int d);
    d = 0;
    if (s && sp < 28) begin
      m_selx = (sp % 14) * 56; m_sely = (sp / 14) * 56;
      m_st = M_SLIDE; m_n = 0; m_x = START_X; m_y = REST_Y; m_vis = 1;
    end else begin
      case (m_st)
        M_SLIDE: begin
          m_n++;
          m_x = START_X - STEP * m_n;
          if (m_x <= REST_X) begin m_x = REST_X; m_st = M_REST; d = 1; end
        end
        M_REST: begin
          if (f) begin m_st = M_FAINT; m_n = 0; end
          else if (h) begin m_st = M_HIT; m_n = 0; m_vis = 1; end
        end
        M_HIT: begin
          if (f) begin m_st = M_FAINT; m_n = 0; m_vis = 1; end
          else begin
            m_n++;
            if (m_n == 24) begin m_st = M_REST; m_vis = 1; d = 1; end
            else m_vis = ((m_n / 4) % 2 == 0) ? 1 : 0;
          end
        end
        M_FAINT: begin
          m_n++;
          if (m_n == 8) begin m_st = M_IDLE; m_vis = 0; m_y = REST_Y; d = 1; end
          else m_y = REST_Y + STEP * m_n;
        end
        default: ;
      endcase
    end
`ifdef SPRITE_SHAKE_EN
    if (m_st == M_HIT) m_x = (m_n % 2 == 0) ? REST_X + SHAKE : REST_X - SHAKE;
    else if (m_st == M_REST || m_st == M_FAINT) m_x = REST_X;
`endif
  endtask

  task automatic push(input string tag, input int d);
    exp_t e;
    e.tag = tag; e.x = m_x; e.y = m_y; e.selx = m_selx; e.sely = m_sely;
    e.vis = m_vis; e.done = d;
    e.busy = (m_st == M_SLIDE || m_st == M_HIT || m_st == M_FAINT) ? 1 : 0;
    sbq.push_back(e);
  endtask

  task automatic frame(input string tag, input bit s, input int sp, input bit h, input bit f);
    int d;
    @(posedge clk); #1;
    if (s) begin start = 1'b1; species = 5'(sp); end
    @(posedge clk); #1;
    start = 1'b0; species = 5'($urandom); hit = h;
    @(posedge clk); #1;
    hit = 1'b0; faint = f;
    @(posedge clk); #1;
    faint = 1'b0;
    model_tick(s, sp, h, f, d);
    push(tag, d);
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issued++;
    vsync = 1'b1;
  endtask

  task automatic reset_dut(input string tag, input int cycles);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    push(tag, 0);
    issued++;
  endtask

  task automatic chk(input string tag, input string what, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  initial begin
    int checked = 0;
    int last_done = 0;
    int idle = 0;
    forever begin
      @(negedge clk);
      if (issued > checked) begin
        exp_t e;
        e = sbq.pop_front();
        chk(e.tag, "x", int'(x), e.x);
        chk(e.tag, "y", int'(y), e.y);
        chk(e.tag, "sel_x", int'(selx), e.selx);
        chk(e.tag, "sel_y", int'(sely), e.sely);
        chk(e.tag, "visible", int'(vis), e.vis);
        chk(e.tag, "busy", int'(busy), e.busy);
        chk(e.tag, "done_pulses", done_cnt - last_done, e.done);
        last_done = done_cnt;
        checked++;
        idle = 0;
      end else begin
        idle++;
      end
      if (stim_done && checked == issued) break;
      if (idle > 2000) begin
        total++; bad++;
        $display("FAIL watchdog: checked %0d of %0d frames", checked, issued);
        break;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b1; start = 1'b0; hit = 1'b0; faint = 1'b0; species = '0;
    model_reset();
    reset_dut("por", 3);

    frame("start17", 1'b1, 17, 1'b0, 1'b0);
    repeat (53) frame("slide17", 1'b0, 0, 1'b0, 1'b0);
    frame("bad_species", 1'b1, 30, 1'b0, 1'b0);
    frame("hit", 1'b0, 0, 1'b1, 1'b0);
    repeat (24) frame("blink", 1'b0, 0, 1'b0, 1'b0);
    frame("faint", 1'b0, 0, 1'b0, 1'b1);
    repeat (8) frame("sink", 1'b0, 0, 1'b0, 1'b0);
    frame("idle_hit", 1'b0, 0, 1'b1, 1'b1);
    frame("start27", 1'b1, 27, 1'b0, 1'b0);
    repeat (53) frame("slide27", 1'b0, 0, 1'b0, 1'b0);
    frame("hit_faint", 1'b0, 0, 1'b1, 1'b1);
    repeat (3) frame("sink2", 1'b0, 0, 1'b0, 1'b0);
    frame("restart", 1'b1, 0, 1'b0, 1'b0);
    repeat (10) frame("slide0", 1'b0, 0, 1'b0, 1'b0);
    reset_dut("mid_slide", 1);
    frame("after_rst", 1'b0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      bit s, h, f;
      int sp;
      s  = ($urandom_range(0, 99) < 6);
      sp = $urandom_range(0, 31);
      h  = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 79) == 0) reset_dut("rand_rst", 1);
      frame("rand", s, sp, h, f);
    end
    stim_done = 1'b1;
  end

endmodule
